// File: rtl/usr_param_seq.sv
// usr_param_seq: parametrised universal shift register with a command
// handshake. A command selects hold, logical shift, rotate, arithmetic shift
// or parallel load. Shift and rotate commands move one bit position per clock
// for cmd_amount steps. busy/done sequence the work, and the serial in/out
// ports let instances chain into wider serial links.
// Optional feature: define USR_ABORT_EN to add a cmd_abort input that stops a
// multi-step operation early.
module usr_param_seq #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_mode,
   input  logic [AMT_W-1:0] cmd_amount,
   input  logic [WIDTH-1:0] load_data,
   input  logic             sin_r,
   input  logic             sin_l,
`ifdef USR_ABORT_EN
   input  logic             cmd_abort,
`endif
   output logic [WIDTH-1:0] data_out,
   output logic             sout_r,
   output logic             sout_l,
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHR  = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_LOAD = 3'b011;
   localparam logic [2:0] MODE_ROR  = 3'b100;
   localparam logic [2:0] MODE_ROL  = 3'b101;
   localparam logic [2:0] MODE_ASR  = 3'b110;

   localparam logic [AMT_W-1:0] AMT_ZERO = '0;
   localparam logic [AMT_W-1:0] AMT_ONE  = AMT_W'(1);

   state_t           r_state;
   logic [WIDTH-1:0] r_data;
   logic [AMT_W-1:0] r_cnt;
   logic [2:0]       r_mode;
   logic             r_busy;
   logic             r_done;

   logic             w_accept;
   logic             w_abort;
   logic             w_is_move;
   logic [WIDTH-1:0] w_step_new;
   logic [WIDTH-1:0] w_step_live;

   // One single-bit move of d under mode m; serial inputs are sampled live.
   function automatic logic [WIDTH-1:0] step_once(input logic [2:0]       m,
                                                  input logic [WIDTH-1:0] d,
                                                  input logic             s_r,
                                                  input logic             s_l);
      logic [WIDTH-1:0] v;
      v = d;
      case (m)
         MODE_SHR: v = {s_r, d[WIDTH-1:1]};
         MODE_SHL: v = {d[WIDTH-2:0], s_l};
         MODE_ROR: v = {d[0], d[WIDTH-1:1]};
         MODE_ROL: v = {d[WIDTH-2:0], d[WIDTH-1]};
         MODE_ASR: v = {d[WIDTH-1], d[WIDTH-1:1]};
         default:  v = d;
      endcase
      return v;
   endfunction

`ifdef USR_ABORT_EN
   assign w_abort = cmd_abort;
`else
   assign w_abort = 1'b0;
`endif

   assign w_accept  = cmd_valid && !r_busy;
   // Hold, load and the reserved code never step; everything else moves bits.
   assign w_is_move = (cmd_mode == MODE_SHR) || (cmd_mode == MODE_SHL) ||
                      (cmd_mode == MODE_ROR) || (cmd_mode == MODE_ROL) ||
                      (cmd_mode == MODE_ASR);

   // First step of a new command uses the incoming mode; later steps use the
   // mode latched at acceptance.
   always_comb begin
      w_step_new  = step_once(cmd_mode, r_data, sin_r, sin_l);
      w_step_live = step_once(r_mode, r_data, sin_r, sin_l);
   end

   // Command FSM: accepts commands, sequences shift steps, registers busy/done.
   always_ff @(posedge clk) begin
      // NOTE: every state register here uses <= so all of them update from the
      // same pre-edge values; blocking assignments would chain within the edge.
      if (!rst) begin
         r_state <= ST_IDLE;
         r_data  <= '0;
         r_cnt   <= '0;
         r_mode  <= MODE_HOLD;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_mode <= cmd_mode;
                  if (cmd_mode == MODE_LOAD) begin
                     r_data <= load_data;
                     r_done <= 1'b1;
                  end else if (w_is_move && (cmd_amount != AMT_ZERO)) begin
                     r_data <= w_step_new;
                     if (cmd_amount == AMT_ONE) begin
                        r_done <= 1'b1;
                     end else begin
                        r_state <= ST_SHIFT;
                        r_busy  <= 1'b1;
                        r_cnt   <= cmd_amount - AMT_ONE;
                     end
                  end else begin
                     // Hold, reserved, or a move of zero positions.
                     r_done <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               if (w_abort) begin
                  // Leave the partially moved value in place.
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
                  r_done  <= 1'b1;
               end else begin
                  r_data <= w_step_live;
                  r_cnt  <= r_cnt - AMT_ONE;
                  // r_cnt counts the steps still owed including this one.
                  if (r_cnt == AMT_ONE) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready = ~r_busy;
   assign busy      = r_busy;
   assign done      = r_done;
   assign data_out  = r_data;
   assign sout_r    = r_data[0];
   assign sout_l    = r_data[WIDTH-1];

endmodule

// File: tb/tb_usr_param_seq.sv
// tb_usr_param_seq: directed-vector bench for usr_param_seq (WIDTH=8, AMT_W=4).
// Define USR_ABORT_EN for both bench and RTL to exercise the abort path.
module tb_usr_param_seq;

   localparam int WIDTH = 8;
   localparam int AMT_W = 4;

   logic             clk;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_mode;
   logic [AMT_W-1:0] cmd_amount;
   logic [WIDTH-1:0] load_data;
   logic             sin_r;
   logic             sin_l;
   logic             cmd_abort;
   logic [WIDTH-1:0] data_out;
   logic             sout_r;
   logic             sout_l;
   logic             busy;
   logic             done;

   int n_vec;
   int n_miss;

   usr_param_seq #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_mode   (cmd_mode),
      .cmd_amount (cmd_amount),
      .load_data  (load_data),
      .sin_r      (sin_r),
      .sin_l      (sin_l),
`ifdef USR_ABORT_EN
      .cmd_abort  (cmd_abort),
`endif
      .data_out   (data_out),
      .sout_r     (sout_r),
      .sout_l     (sout_l),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its hand-computed expectation.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command for exactly one edge (the accept edge T0).
   task automatic issue(input logic [2:0] m, input logic [AMT_W-1:0] a,
                        input logic [WIDTH-1:0] ld);
      cmd_valid  = 1'b1;
      cmd_mode   = m;
      cmd_amount = a;
      load_data  = ld;
      tick();
      cmd_valid  = 1'b0;
   endtask

   // Step until done is seen, bounded; returns the number of edges taken.
   task automatic wait_done(input string tag, output int edges);
      edges = 0;
      while (!done && edges < 20) begin
         tick();
         edges++;
      end
      if (!done) chk({tag, "_timeout"}, 32'(done), 32'd1);
   endtask

   int edges;

   initial begin
      n_vec      = 0;
      n_miss     = 0;
      rst        = 1'b0;
      cmd_valid  = 1'b0;
      cmd_mode   = 3'b000;
      cmd_amount = '0;
      load_data  = '0;
      sin_r      = 1'b0;
      sin_l      = 1'b0;
      cmd_abort  = 1'b0;

      // Reset for two cycles.
      tick();
      tick();
      chk("rst_data",  32'(data_out),  32'h00);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_done",  32'(done),      32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      rst = 1'b1;
      tick();

      // Parallel load.
      issue(3'b011, 4'd0, 8'hA5);
      chk("load_data", 32'(data_out), 32'hA5);
      chk("load_done", 32'(done),     32'd1);
      chk("load_busy", 32'(busy),     32'd0);
      chk("load_sout", 32'({sout_l, sout_r}), 32'h3);
      tick();
      chk("load_done_clr", 32'(done), 32'd0);

      // Right shift by 3 with sin_r=1; a load request while busy is ignored.
      sin_r = 1'b1;
      issue(3'b001, 4'd3, 8'h00);
      chk("shr_s1_data",  32'(data_out),  32'hD2);
      chk("shr_s1_busy",  32'(busy),      32'd1);
      chk("shr_s1_ready", 32'(cmd_ready), 32'd0);
      chk("shr_s1_done",  32'(done),      32'd0);
      cmd_valid = 1'b1;
      cmd_mode  = 3'b011;
      load_data = 8'h55;
      tick();
      chk("shr_s2_data", 32'(data_out), 32'hE9);
      chk("shr_s2_busy", 32'(busy),     32'd1);
      tick();
      cmd_valid = 1'b0;
      chk("shr_end_data",  32'(data_out),  32'hF4);
      chk("shr_end_done",  32'(done),      32'd1);
      chk("shr_end_busy",  32'(busy),      32'd0);
      chk("shr_end_ready", 32'(cmd_ready), 32'd1);
      tick();
      chk("shr_done_clr", 32'(done),     32'd0);
      chk("shr_hold",     32'(data_out), 32'hF4);
      sin_r = 1'b0;

      // Rotate left by 9 wraps to a single rotate.
      issue(3'b011, 4'd0, 8'h81);
      issue(3'b101, 4'd9, 8'h00);
      chk("rol_busy", 32'(busy), 32'd1);
      wait_done("rol", edges);
      chk("rol_edges", 32'(edges),    32'd8);
      chk("rol_data",  32'(data_out), 32'h03);

      // Arithmetic shift right by 2, then a zero-amount command.
      issue(3'b011, 4'd0, 8'h90);
      issue(3'b110, 4'd2, 8'h00);
      chk("asr_s1_data", 32'(data_out), 32'hC8);
      tick();
      chk("asr_data", 32'(data_out), 32'hE4);
      chk("asr_done", 32'(done),     32'd1);
      issue(3'b110, 4'd0, 8'h00);
      chk("zero_data", 32'(data_out), 32'hE4);
      chk("zero_done", 32'(done),     32'd1);
      chk("zero_busy", 32'(busy),     32'd0);

      // Reserved code holds and completes at once.
      issue(3'b111, 4'd5, 8'h00);
      chk("rsv_data", 32'(data_out), 32'hE4);
      chk("rsv_done", 32'(done),     32'd1);

      // Logical left shift past the width fills with serial-input samples.
      sin_l = 1'b1;
      issue(3'b010, 4'd10, 8'h00);
      wait_done("shl_wrap", edges);
      chk("shl_wrap_edges", 32'(edges),    32'd9);
      chk("shl_wrap_data",  32'(data_out), 32'hFF);
      sin_l = 1'b0;

      // Reset on the second step of a 5-step shift; a concurrent command is dropped.
      issue(3'b011, 4'd0, 8'h3C);
      issue(3'b001, 4'd5, 8'h00);
      chk("mid_s1_data", 32'(data_out), 32'h1E);
      rst       = 1'b0;
      cmd_valid = 1'b1;
      cmd_mode  = 3'b011;
      load_data = 8'h55;
      tick();
      rst       = 1'b1;
      cmd_valid = 1'b0;
      chk("mid_rst_data", 32'(data_out), 32'h00);
      chk("mid_rst_busy", 32'(busy),     32'd0);
      chk("mid_rst_done", 32'(done),     32'd0);
      tick();
      chk("mid_rst_done2", 32'(done),     32'd0);
      chk("mid_rst_hold",  32'(data_out), 32'h00);

`ifdef USR_ABORT_EN
      // Abort at T0+2 of a 6-step left shift keeps the partial result.
      issue(3'b011, 4'd0, 8'h01);
      issue(3'b010, 4'd6, 8'h00);
      tick();
      chk("abt_pre_data", 32'(data_out), 32'h04);
      cmd_abort = 1'b1;
      tick();
      cmd_abort = 1'b0;
      chk("abt_data", 32'(data_out), 32'h04);
      chk("abt_busy", 32'(busy),     32'd0);
      chk("abt_done", 32'(done),     32'd1);
      tick();
      chk("abt_done_clr", 32'(done),     32'd0);
      chk("abt_hold",     32'(data_out), 32'h04);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/usr_param_seq.md
Name: usr_param_seq

Overview:
- Parametrised universal shift register with a command handshake.
- Supports parallel load, logical shift, rotate and arithmetic shift, each executed over a programmable bit count, one bit position per clock.
- Adds busy/done sequencing and serial in/out ports so instances chain into wider serial links.
- Sits under datapath/serialiser logic in the same designs as the existing fixed 4-bit universal shift register.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AMT_W, 4, width of cmd_amount. Must satisfy 2^AMT_W > WIDTH.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command; equals ~busy.
- cmd_mode  input  3  operation select, see Behaviour.
- cmd_amount  input  AMT_W  bit positions to move (shift/rotate modes).
- load_data  input  WIDTH  parallel load value.
- sin_r  input  1  serial input entering the MSB on right shift.
- sin_l  input  1  serial input entering the LSB on left shift.
- data_out  output  WIDTH  register contents.
- sout_r  output  1  data_out[0], combinational.
- sout_l  output  1  data_out[WIDTH-1], combinational.
- busy  output  1  multi-cycle operation in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: rst sampled low at a clk edge sets data_out=0, busy=0, done=0, shift counter=0 and state=IDLE. A command accepted in the same cycle as reset is discarded.
- cmd_mode encoding:
  - 000 hold
  - 001 shift right: {sin_r, d[W-1:1]}
  - 010 shift left: {d[W-2:0], sin_l}
  - 011 parallel load
  - 100 rotate right
  - 101 rotate left
  - 110 arithmetic shift right: MSB replicated
  - 111 reserved, treated as hold
- Accept: a command is accepted on an edge where cmd_valid=1 and cmd_ready=1. Call that edge T0. With no command accepted, data_out holds.
- States: IDLE and SHIFT.
  - IDLE: cmd_ready=1.
  - SHIFT: cmd_ready=0, busy=1.
- Load, hold, reserved, or any shift/rotate mode with cmd_amount=0:
  - At T0, data_out takes load_data (load) or is unchanged (the others).
  - done=1 for the cycle after T0. State stays IDLE.
- Shift/rotate with cmd_amount=n>=1:
  - The first single-bit step happens at T0; further steps occur at edges T0+1 .. T0+n-1.
  - If n=1: stay IDLE. done=1 for the cycle after T0.
  - If n>1: go to SHIFT at T0 with counter=n-1. Decrement per step. Return to IDLE at edge T0+n-1. done=1 for the cycle after that edge.
- Busy timing: busy is high from after T0 up to and including the cycle before done.
- Latched and live signals:
  - Mode is latched at T0.
  - sin_r and sin_l are sampled live at each step edge, which allows streaming.
- Wrap-around:
  - n>WIDTH is legal.
  - Rotates wrap modulo WIDTH in effect; they simply take n steps.
  - Logical shifts with n>=WIDTH end with the register full of serial-input samples.
- Back-to-back: done and cmd_ready are both high in the completion cycle, so a new command may be accepted on the edge right after the last step. Minimum command spacing is 1 cycle for single-step operations.
- Ignored inputs: cmd_valid while busy is ignored. The command is not queued.

Optional Feature:
- Macro: USR_ABORT_EN.
- When defined:
  - Adds input cmd_abort (1 bit).
  - cmd_abort=1 at an edge while in SHIFT: the step on that edge is not performed, state returns to IDLE, counter clears, and done pulses the next cycle. data_out keeps its partially shifted value.
  - cmd_abort in IDLE has no effect.
  - If abort and reset coincide, reset wins.
- When undefined: no port is added and every operation runs to completion.

Test Plan (WIDTH=8):
- Reset then load: rst=0 for 2 cycles, then load_data=8'hA5 with mode 011 → data_out=8'hA5 after T0, done pulses 1 cycle, busy never asserts.
- Multi-step right shift: data_out=8'hA5, mode 001, amount=3, sin_r=1 → busy high for 2 cycles, data_out=8'hF4, done single pulse, cmd_ready low during busy.
- Rotate wrap: data_out=8'h81, mode 101, amount=9 → data_out=8'h03 after 9 steps, done after the 9th step.
- Arithmetic shift and zero amount:
  - data_out=8'h90, mode 110, amount=2 → 8'hE4.
  - Then amount=0 → data unchanged, done pulses.
- Mid-operation reset and ignored command: rst=0 during the 2nd step of a 5-step shift → data_out=0, busy=0, no done. A cmd_valid issued while busy is ignored and data_out is unaffected.
- With USR_ABORT_EN: data_out=8'h01, mode 010, amount=6, sin_l=0, cmd_abort at edge T0+2 → data_out=8'h04, busy drops, done pulses once.
